// File: rtl/shift_pkg.sv
// Shared definitions for the pipelined shift unit: op encodings and a
// constant log2 helper used to size amount fields.
package shift_pkg;

  typedef enum logic [2:0] {
    SH_SLL = 3'b000,
    SH_SRL = 3'b001,
    SH_SRA = 3'b010,
    SH_ROR = 3'b011,
    SH_ROL = 3'b100
  } op_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result++;
    end
    return result;
  endfunction

endpackage

// File: rtl/shift_slice.sv
// One register slice of the shift pipeline: applies its barrel levels to the
// incoming operand, then registers the result with a valid/ready handshake.
module shift_slice
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = 5,
  parameter int TAG_W = 5,
  parameter int FIRST = 0,
  parameter int NLEV  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] data_i,
  input  logic [SHW-1:0]   amt_i,
  input  logic [2:0]       op_i,
  input  logic             fill_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] data_o,
  output logic [SHW-1:0]   amt_o,
  output logic [2:0]       op_o,
  output logic             fill_o,
  output logic [TAG_W-1:0] tag_o
);

  localparam logic [WIDTH-1:0] ONES = '1;

  logic [WIDTH-1:0] shifted;
  logic             valid_q;

  // Levels outside [FIRST, FIRST+NLEV) belong to other slices; a trailing
  // slice may own none of them and then only re-registers.
  always_comb begin
    shifted = data_i;
    for (int k = 0; k < SHW; k++) begin
      if (k >= FIRST && k < FIRST + NLEV && amt_i[k]) begin
        case (op_i)
          SH_SLL:         shifted = shifted << (1 << k);
          SH_SRL, SH_SRA: shifted = (shifted >> (1 << k)) |
                                    (fill_i ? ~(ONES >> (1 << k)) : '0);
          SH_ROR:         shifted = (shifted >> (1 << k)) |
                                    (shifted << (WIDTH - (1 << k)));
          default:        shifted = shifted;
        endcase
      end
    end
  end

  assign in_ready_o  = !valid_q || out_ready_i;
  assign out_valid_o = valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (in_ready_o) begin
      valid_q <= in_valid_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_o <= '0;
      amt_o  <= '0;
      op_o   <= SH_SLL;
      fill_o <= 1'b0;
      tag_o  <= '0;
    end else if (in_valid_i && in_ready_o) begin
      data_o <= shifted;
      amt_o  <= amt_i;
      op_o   <= op_i;
      fill_o <= fill_i;
      tag_o  <= tag_i;
    end
  end

endmodule

// File: rtl/shift_pipe.sv
// Pipelined shifter for the execute stage: normalises the request on entry,
// then spreads the barrel levels over STAGES handshaked register slices.
module shift_pipe
  import shift_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int TAG_W  = 5,
  localparam int SHW   = clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] data_i,
  input  logic [WIDTH-1:0] rs_i,
  input  logic [SHW-1:0]   shamt_i,
  input  logic             var_shift_i,
  input  logic [2:0]       op_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic [TAG_W-1:0] tag_o,
  output logic             zero_o
);

  localparam int             LPS     = (SHW + STAGES - 1) / STAGES;
  localparam logic [SHW-1:0] AMT_ONE = 1;

  logic [SHW-1:0]   amt_sel;
  logic [SHW-1:0]   norm_amt;
  logic [2:0]       norm_op;
  logic             norm_fill;

  logic             v_c [STAGES+1];
  logic [WIDTH-1:0] d_c [STAGES+1];
  logic [SHW-1:0]   a_c [STAGES+1];
  logic [2:0]       o_c [STAGES+1];
  logic             f_c [STAGES+1];
  logic [TAG_W-1:0] t_c [STAGES+1];
  logic             unused_bits;

  assign amt_sel = var_shift_i ? rs_i[SHW-1:0] : shamt_i;

  // ROL becomes ROR by the two's complement of the amount (0 stays 0), and
  // reserved ops become a zero-amount SLL so the slices only see four ops.
  always_comb begin
    norm_amt  = amt_sel;
    norm_op   = op_i;
    norm_fill = 1'b0;
    case (op_i)
      SH_SLL, SH_SRL, SH_ROR: norm_op = op_i;
      SH_SRA: norm_fill = data_i[WIDTH-1];
      SH_ROL: begin
        norm_op  = SH_ROR;
        norm_amt = ~amt_sel + AMT_ONE;
      end
      default: begin
        norm_op  = SH_SLL;
        norm_amt = '0;
      end
    endcase
  end

  assign v_c[0] = in_valid_i;
  assign d_c[0] = data_i;
  assign a_c[0] = norm_amt;
  assign o_c[0] = norm_op;
  assign f_c[0] = norm_fill;
  assign t_c[0] = tag_i;

  // Ready wires live per slice so the combinational chain never loops
  // through a single shared vector.
  for (genvar s = 0; s < STAGES; s++) begin : g_slice
    logic up_rdy;
    logic down_rdy;

    if (s == STAGES - 1) begin : g_last
      assign down_rdy = out_ready_i;
    end else begin : g_mid
      assign down_rdy = g_slice[s+1].up_rdy;
    end

    shift_slice #(
      .WIDTH (WIDTH),
      .SHW   (SHW),
      .TAG_W (TAG_W),
      .FIRST (s * LPS),
      .NLEV  (LPS)
    ) u_slice (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush_i     (flush_i),
      .in_valid_i  (v_c[s]),
      .in_ready_o  (up_rdy),
      .data_i      (d_c[s]),
      .amt_i       (a_c[s]),
      .op_i        (o_c[s]),
      .fill_i      (f_c[s]),
      .tag_i       (t_c[s]),
      .out_valid_o (v_c[s+1]),
      .out_ready_i (down_rdy),
      .data_o      (d_c[s+1]),
      .amt_o       (a_c[s+1]),
      .op_o        (o_c[s+1]),
      .fill_o      (f_c[s+1]),
      .tag_o       (t_c[s+1])
    );
  end

  assign in_ready_o  = g_slice[0].up_rdy;
  assign out_valid_o = v_c[STAGES];
  assign result_o    = d_c[STAGES];
  assign tag_o       = t_c[STAGES];
  assign zero_o      = (d_c[STAGES] == '0);

  assign unused_bits = ^{rs_i[WIDTH-1:SHW], a_c[STAGES], o_c[STAGES], f_c[STAGES]};

endmodule
